// File: rtl/restoring_divider_pkg.sv
// ============================================================================
// restoring_divider_pkg
// Shared types, default width and helper function for the restoring divider.
// Revision: 1.0
// ============================================================================
`default_nettype none

package restoring_divider_pkg;

  localparam int DEFAULT_WIDTH = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  // Never returns less than 1 so a counter always has at least one bit.
  function automatic int clog2(input int value);
    int bits;
    bits = 0;
    while ((1 << bits) < value) bits++;
    return (bits < 1) ? 1 : bits;
  endfunction

endpackage

`default_nettype wire

// File: rtl/restoring_divider_sub_stage.sv
// ============================================================================
// sub_stage
// Combinational N-bit ripple subtractor in a + ~b + 1 form; cout=1 means no borrow.
// Revision: 1.0
// ============================================================================
`default_nettype none

module sub_stage #(
  parameter int N = 5
) (
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  output logic [N-1:0] diff,
  output logic         cout
);

  logic [N:0] w_c;

  assign w_c[0] = 1'b1;

  for (genvar i = 0; i < N; i++) begin : g_bit
    assign diff[i]   = a[i] ^ ~b[i] ^ w_c[i];
    assign w_c[i+1]  = (a[i] & ~b[i]) | (a[i] & w_c[i]) | (~b[i] & w_c[i]);
  end

  assign cout = w_c[N];

endmodule

`default_nettype wire

// File: rtl/restoring_divider.sv
// ============================================================================
// restoring_divider
// Iterative unsigned restoring divider, one trial subtraction per clock.
// Optional macro RESTDIV_DIV0_ERR_EN adds div0_err and a fast divide-by-zero path.
// Revision: 1.0
// ============================================================================
`default_nettype none

module restoring_divider
  import restoring_divider_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
`ifdef RESTDIV_DIV0_ERR_EN
  output logic [WIDTH-1:0] remainder,
  output logic             div0_err
`else
  output logic [WIDTH-1:0] remainder
`endif
);

  localparam int              c_cnt_w = clog2(WIDTH);
  localparam logic [c_cnt_w-1:0] c_last = c_cnt_w'(WIDTH - 1);

  state_t               r_state;
  state_t               w_state_next;
  logic [WIDTH-1:0]     r_q;
  logic [WIDTH-1:0]     r_d;
  logic [WIDTH:0]       r_r;
  logic [c_cnt_w-1:0]   r_cnt;

  logic [WIDTH:0]       w_t;
  logic [WIDTH:0]       w_diff;
  logic                 w_cout;
  logic [WIDTH-1:0]     w_q_next;
  logic [WIDTH:0]       w_r_next;
  logic                 w_accept;
  logic                 w_div0;
  logic                 w_unused_r_msb;

  // Partial remainder MSB is always 0 after an iteration; only the low bits feed back.
  assign w_t            = {r_r[WIDTH-1:0], r_q[WIDTH-1]};
  assign w_unused_r_msb = r_r[WIDTH];

  sub_stage #(.N(WIDTH + 1)) u_sub (
    .a    (w_t),
    .b    ({1'b0, r_d}),
    .diff (w_diff),
    .cout (w_cout)
  );

  assign w_q_next = {r_q[WIDTH-2:0], w_cout};
  assign w_r_next = w_cout ? w_diff : w_t;
  assign w_accept = (r_state == IDLE) && start;

`ifdef RESTDIV_DIV0_ERR_EN
  assign w_div0 = (divisor == '0);
`else
  assign w_div0 = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    busy         = 1'b0;
    done         = 1'b0;
    case (r_state)
      IDLE: if (start) w_state_next = w_div0 ? DONE : BUSY;
      BUSY: begin
        busy = 1'b1;
        if (r_cnt == c_last) w_state_next = DONE;
      end
      DONE: begin
        busy         = 1'b1;
        done         = 1'b1;
        w_state_next = IDLE;
      end
      default: w_state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_q       <= '0;
      r_d       <= '0;
      r_r       <= '0;
      r_cnt     <= '0;
      quotient  <= '0;
      remainder <= '0;
`ifdef RESTDIV_DIV0_ERR_EN
      div0_err  <= 1'b0;
`endif
    end else if (w_accept) begin
      r_q   <= dividend;
      r_d   <= divisor;
      r_r   <= '0;
      r_cnt <= '0;
`ifdef RESTDIV_DIV0_ERR_EN
      div0_err <= w_div0;
      if (w_div0) begin
        quotient  <= '1;
        remainder <= dividend;
      end
`endif
    end else if (r_state == BUSY) begin
      r_q   <= w_q_next;
      r_r   <= w_r_next;
      r_cnt <= r_cnt + 1'b1;
      if (r_cnt == c_last) begin
        quotient  <= w_q_next;
        remainder <= w_r_next[WIDTH-1:0];
      end
    end
  end

endmodule

`default_nettype wire
